instr_fetch_decode: RTL and testbench

Fetch/decode stage directly upstream of the ALU control unit in the single-cycle processor. It owns the PC, issues fetches to instruction memory over a req/ready + rvalid handshake, and holds each instruction in an instruction register (IR). It splits the instruction into fields, presenting function_code and the I-type select (alu_src_sel) consumed by the control unit. Output is held stable until the execute side accepts it.

---
 rtl/instr_fetch_decode_pkg.sv | 52 +++++
 rtl/instr_fetch_decode_if.sv | 20 ++
 rtl/instr_fetch_decode_pc_reg.sv | 25 ++
 rtl/instr_fetch_decode.sv | 147 ++++++++++++++
 tb/tb_instr_fetch_decode.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_decode_pkg.sv
// fetch_pkg: shared constants and types for the instr_fetch_decode slice.
//   - fetch_state_e : 3-bit FSM state encoding
//   - OP_RTYPE/OP_HALT : opcodes with special meaning to this stage
//   - field bit positions of the 32-bit instruction word
//   - ir_fields_t / decode_ir : field split of the instruction register
package fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_VALID  = 3'd3,
    S_DRAIN  = 3'd4,
    S_HALTED = 3'd5
  } fetch_state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam int OPC_LSB = 26;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;
  localparam int FN_LSB  = 0;
  localparam int IMM_LSB = 0;

  localparam int PC_INC = 4;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  function_code;
    logic [15:0] imm16;
    logic        alu_src_sel;
  } ir_fields_t;

  function automatic ir_fields_t decode_ir(input logic [31:0] ir);
    ir_fields_t f;
    f.opcode        = ir[OPC_LSB +: 6];
    f.rs            = ir[RS_LSB  +: 5];
    f.rt            = ir[RT_LSB  +: 5];
    f.rd            = ir[RD_LSB  +: 5];
    f.function_code = ir[FN_LSB  +: 6];
    f.imm16         = ir[IMM_LSB +: 16];
    // Any non-R-type opcode selects the immediate operand.
    f.alu_src_sel   = (ir[OPC_LSB +: 6] != OP_RTYPE);
    return f;
  endfunction

endpackage

// File: rtl/instr_fetch_decode_if.sv
// instr_fetch_decode_if: instruction-memory fetch channel.
//   imem_req/imem_addr   : request, held until imem_ready
//   imem_ready           : memory accepts request this cycle
//   imem_rvalid/rdata    : response data (at least one cycle after accept)
// modports: master = fetch stage, slave = instruction memory.
interface instr_fetch_decode_if #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32
) ();
  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic                   imem_ready;
  logic                   imem_rvalid;
  logic [INSTR_WIDTH-1:0] imem_rdata;

  modport master (output imem_req, imem_addr,
                  input  imem_ready, imem_rvalid, imem_rdata);
  modport slave  (input  imem_req, imem_addr,
                  output imem_ready, imem_rvalid, imem_rdata);
endinterface

// File: rtl/instr_fetch_decode_pc_reg.sv
// pc_reg: program counter.
//   load/load_pc : redirect target, low two bits forced to 0 (wins over inc)
//   inc          : advance by PC_INC, wrapping modulo 2^PC_WIDTH
//   pc           : current PC, async reset to RESET_PC
module pc_reg
  import fetch_pkg::*;
#(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [PC_WIDTH-1:0] load_pc,
  input  logic                inc,
  output logic [PC_WIDTH-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pc <= RESET_PC;
    else if (load) pc <= {load_pc[PC_WIDTH-1:2], 2'b00};
    else if (inc)  pc <= pc + PC_WIDTH'(PC_INC);
  end

endmodule

// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: PC ownership, single-outstanding instruction fetch,
// instruction register and field decode for the ALU control unit.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   start                 : leave IDLE and begin fetching
//   imem                  : fetch channel (instr_fetch_decode_if.master)
//   redirect_valid/pc     : taken branch/jump target (top priority)
//   ex_ready              : downstream accepts the held instruction
//   instr_valid, opcode, function_code, alu_src_sel, rs, rt, rd, imm16,
//   pc_out                : decoded instruction and its PC
//   halted                : HALT opcode retired, terminal until reset
//   instr_count           : accepted-instruction counter (INSTR_COUNT_EN)
// Build option: define INSTR_COUNT_EN to add the instr_count output.
module instr_fetch_decode
  import fetch_pkg::*;
#(
  parameter int                  PC_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int                  INSTR_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  instr_fetch_decode_if.master imem,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                ex_ready,
  output logic                instr_valid,
  output logic [5:0]          opcode,
  output logic [5:0]          function_code,
  output logic                alu_src_sel,
  output logic [4:0]          rs,
  output logic [4:0]          rt,
  output logic [4:0]          rd,
  output logic [15:0]         imm16,
  output logic [PC_WIDTH-1:0] pc_out,
`ifdef INSTR_COUNT_EN
  output logic [31:0]         instr_count,
`endif
  output logic                halted
);

  fetch_state_e           state;
  logic [INSTR_WIDTH-1:0] ir;
  logic [PC_WIDTH-1:0]    pc;
  logic                   req_q;
  ir_fields_t             f;

  // Redirects only matter while a fetch sequence is in flight.
  logic redir_act, accept, pc_inc;
  assign redir_act = redirect_valid &&
                     (state inside {S_REQ, S_WAIT, S_VALID, S_DRAIN});
  assign accept    = (state == S_VALID) && ex_ready && !redirect_valid;
  assign pc_inc    = accept && (f.opcode != OP_HALT);

  pc_reg #(.PC_WIDTH(PC_WIDTH), .RESET_PC(RESET_PC)) u_pc (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (redir_act),
    .load_pc (redirect_pc),
    .inc     (pc_inc),
    .pc      (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      req_q       <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      ir          <= '0;
      pc_out      <= RESET_PC;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state <= S_REQ;
          req_q <= 1'b1;
        end
        S_REQ: begin
          // Redirect keeps us in REQ; only the address moves.
          if (!redirect_valid && imem.imem_ready) begin
            state <= S_WAIT;
            req_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            // Response already here: drop it and refetch; else drain it.
            state <= imem.imem_rvalid ? S_REQ : S_DRAIN;
            req_q <= imem.imem_rvalid;
          end else if (imem.imem_rvalid) begin
            ir          <= imem.imem_rdata;
            pc_out      <= pc;
            state       <= S_VALID;
            instr_valid <= 1'b1;
          end
        end
        S_VALID: begin
          if (redirect_valid) begin
            state       <= S_REQ;
            req_q       <= 1'b1;
            instr_valid <= 1'b0;
          end else if (ex_ready) begin
            instr_valid <= 1'b0;
            if (f.opcode == OP_HALT) begin
              state  <= S_HALTED;
              halted <= 1'b1;
            end else begin
              state <= S_REQ;
              req_q <= 1'b1;
            end
          end
        end
        S_DRAIN: if (imem.imem_rvalid) begin
          state <= S_REQ;
          req_q <= 1'b1;
        end
        S_HALTED: ;
        default: begin
          state       <= S_IDLE;
          req_q       <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef INSTR_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instr_count <= '0;
    else if (accept) instr_count <= instr_count + 32'd1;
  end
`endif

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc;

  assign f             = decode_ir(ir);
  assign opcode        = f.opcode;
  assign function_code = f.function_code;
  assign alu_src_sel   = f.alu_src_sel;
  assign rs            = f.rs;
  assign rt            = f.rt;
  assign rd            = f.rd;
  assign imm16         = f.imm16;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb_instr_fetch_decode: directed-vector bench for instr_fetch_decode.
// Drives the fetch channel by hand (1-cycle memory unless noted) and
// compares outputs against hand-computed values, 1 time unit after the
// rising edge.
module tb_instr_fetch_decode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ex_ready = 1'b0;
  logic        instr_valid, alu_src_sel, halted;
  logic [5:0]  opcode, function_code;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [31:0] pc_out;
`ifdef INSTR_COUNT_EN
  logic [31:0] instr_count;
`endif

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_fetch_decode_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) bus ();

  instr_fetch_decode #(.PC_WIDTH(32), .RESET_PC(32'h0), .INSTR_WIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .imem           (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ex_ready       (ex_ready),
    .instr_valid    (instr_valid),
    .opcode         (opcode),
    .function_code  (function_code),
    .alu_src_sel    (alu_src_sel),
    .rs             (rs),
    .rt             (rt),
    .rd             (rd),
    .imm16          (imm16),
    .pc_out         (pc_out),
`ifdef INSTR_COUNT_EN
    .instr_count    (instr_count),
`endif
    .halted         (halted)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept the pending request, then return data after lat cycles.
  task automatic fetch(input logic [31:0] data, input int lat);
    bus.imem_ready = 1'b1;
    tick();
    bus.imem_ready = 1'b0;
    repeat (lat - 1) tick();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = data;
    tick();
    bus.imem_rvalid = 1'b0;
  endtask

  task automatic accept_instr();
    ex_ready = 1'b1;
    tick();
    ex_ready = 1'b0;
  endtask

  initial begin
    bus.imem_ready  = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;

    // Reset state
    #2;
    chk("rst_req",   32'(bus.imem_req), 32'h0);
    chk("rst_addr",  bus.imem_addr, 32'h0);
    chk("rst_vld",   32'(instr_valid), 32'h0);
    chk("rst_pcout", pc_out, 32'h0);
    chk("rst_halt",  32'(halted), 32'h0);
    chk("rst_fn",    32'(function_code), 32'h0);
    chk("rst_alu",   32'(alu_src_sel), 32'h0);
`ifdef INSTR_COUNT_EN
    chk("rst_cnt",   instr_count, 32'h0);
`endif
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_req", 32'(bus.imem_req), 32'h0);

    // R-type at 0, 3-cycle latency REQ->WAIT->VALID
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_req",  32'(bus.imem_req), 32'h1);
    chk("t1_addr", bus.imem_addr, 32'h0);
    bus.imem_ready  = 1'b1;
    bus.imem_rvalid = 1'b1;       // same cycle as ready: must be ignored
    bus.imem_rdata  = 32'hBAD0_BAD0;
    tick();
    bus.imem_ready  = 1'b0;
    bus.imem_rvalid = 1'b0;
    chk("t1_wait_req", 32'(bus.imem_req), 32'h0);
    chk("t1_wait_vld", 32'(instr_valid), 32'h0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0000_0820;
    tick();
    bus.imem_rvalid = 1'b0;
    chk("t1_vld",   32'(instr_valid), 32'h1);
    chk("t1_fn",    32'(function_code), 32'h20);
    chk("t1_alu",   32'(alu_src_sel), 32'h0);
    chk("t1_rd",    32'(rd), 32'h1);
    chk("t1_pcout", pc_out, 32'h0);
    accept_instr();
    chk("t1_next_addr", bus.imem_addr, 32'h4);
    chk("t1_next_req",  32'(bus.imem_req), 32'h1);
    chk("t1_next_vld",  32'(instr_valid), 32'h0);

    // I-type held while ex_ready=0
    fetch(32'h2001_0005, 1);
    for (int i = 0; i < 5; i++) begin
      chk("t2_vld",  32'(instr_valid), 32'h1);
      chk("t2_op",   32'(opcode), 32'h08);
      chk("t2_alu",  32'(alu_src_sel), 32'h1);
      chk("t2_imm",  32'(imm16), 32'h0005);
      chk("t2_rt",   32'(rt), 32'h1);
      chk("t2_pc",   bus.imem_addr, 32'h4);
      chk("t2_req",  32'(bus.imem_req), 32'h0);
      tick();
    end
    chk("t2_pcout", pc_out, 32'h4);
    accept_instr();
    chk("t2_next_addr", bus.imem_addr, 32'h8);

    // Redirect in WAIT, response 2 cycles later is discarded
    bus.imem_ready = 1'b1;
    tick();
    bus.imem_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    chk("t3_drain_req",  32'(bus.imem_req), 32'h0);
    chk("t3_drain_vld",  32'(instr_valid), 32'h0);
    chk("t3_drain_addr", bus.imem_addr, 32'h100);
    tick();
    chk("t3_drain_hold", 32'(bus.imem_req), 32'h0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    tick();
    bus.imem_rvalid = 1'b0;
    chk("t3_req",  32'(bus.imem_req), 32'h1);
    chk("t3_addr", bus.imem_addr, 32'h100);
    chk("t3_vld",  32'(instr_valid), 32'h0);

    // Redirect in REQ to 0xFFFF_FFFF, accept -> PC wraps to 0
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    chk("t4_addr", bus.imem_addr, 32'hFFFF_FFFC);
    chk("t4_req",  32'(bus.imem_req), 32'h1);
    fetch(32'h0000_0820, 2);
    chk("t4_pcout", pc_out, 32'hFFFF_FFFC);
    chk("t4_vld",   32'(instr_valid), 32'h1);
    accept_instr();
    chk("t4_wrap", bus.imem_addr, 32'h0);

    // Redirect and ex_ready together in VALID: redirect wins
    fetch(32'h0000_0820, 1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    ex_ready       = 1'b1;
    tick();
    redirect_valid = 1'b0;
    ex_ready       = 1'b0;
    chk("t5_addr", bus.imem_addr, 32'h40);
    chk("t5_vld",  32'(instr_valid), 32'h0);
    chk("t5_req",  32'(bus.imem_req), 32'h1);

    // HALT
    fetch(32'hFC00_0000, 1);
    chk("t6_op",    32'(opcode), 32'h3F);
    chk("t6_alu",   32'(alu_src_sel), 32'h1);
    chk("t6_pcout", pc_out, 32'h40);
    accept_instr();
    chk("t6_halt", 32'(halted), 32'h1);
    chk("t6_vld",  32'(instr_valid), 32'h0);
    chk("t6_req",  32'(bus.imem_req), 32'h0);
`ifdef INSTR_COUNT_EN
    chk("t6_cnt",  instr_count, 32'd4);
`endif
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("t6_start_req", 32'(bus.imem_req), 32'h0);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    chk("t6_redir_ign", bus.imem_addr, 32'h40);
    chk("t6_halt_hold", 32'(halted), 32'h1);

    // Reset while HALTED
    rst_n = 1'b0;
    #1;
    chk("t7_halt", 32'(halted), 32'h0);
    chk("t7_addr", bus.imem_addr, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t7_idle_req", 32'(bus.imem_req), 32'h0);

    // Async reset mid-WAIT with a non-zero IR
    start = 1'b1;
    tick();
    start = 1'b0;
    fetch(32'h2001_0005, 1);
    chk("t8_op_pre", 32'(opcode), 32'h08);
    accept_instr();
    bus.imem_ready = 1'b1;
    tick();
    bus.imem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t8_req",   32'(bus.imem_req), 32'h0);
    chk("t8_addr",  bus.imem_addr, 32'h0);
    chk("t8_vld",   32'(instr_valid), 32'h0);
    chk("t8_op",    32'(opcode), 32'h0);
    chk("t8_imm",   32'(imm16), 32'h0);
    chk("t8_alu",   32'(alu_src_sel), 32'h0);
    chk("t8_pcout", pc_out, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t8_re_addr", bus.imem_addr, 32'h0);
    fetch(32'h0000_0820, 1);
    chk("t8_re_vld", 32'(instr_valid), 32'h1);
    chk("t8_re_imm", 32'(imm16), 32'h0820);
    chk("t8_re_op",  32'(opcode), 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
